// File: rtl/pdm_deserializer_if.sv
// Word-side link between the PDM deserializer and its consumer:
// the packed word, its valid flag, the consumer's ack and the overrun flag.
interface pdm_deserializer_if #(
  parameter int WORD_LENGTH = 16
) ();
  logic [WORD_LENGTH-1:0] Data_o;
  logic                   valid_o;
  logic                   ack_i;
  logic                   overrun_o;

  modport master (
    output Data_o,
    output valid_o,
    output overrun_o,
    input  ack_i
  );

  modport slave (
    input  Data_o,
    input  valid_o,
    input  overrun_o,
    output ack_i
  );
endinterface

// File: rtl/pdm_deserializer.sv
// PDM microphone front end: generates the mic clock, samples the 1-bit stream on each
// mic-clock rise and packs WORD_LENGTH bits MSB-first into a word held for a valid/ack consumer.
module pdm_deserializer #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000,
  parameter int WARMUP_BITS        = 16
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               enable_i,
  input  logic               pdm_data_i,
  output logic               pdm_clk_o,
  output logic               pdm_lrsel_o,
  pdm_deserializer_if.master word_if
);

  localparam int HALF   = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY / 2;
  localparam int CNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int IDX_W  = $clog2(WORD_LENGTH);
  localparam int WARM_W = (WARMUP_BITS > 0) ? $clog2(WARMUP_BITS + 1) : 1;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   pdm_clk_q, pdm_clk_d;
  logic [WARM_W-1:0]      warm_q, warm_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic div_run, div_wrap, rise, warm_tick, capture, word_done;

  // State register
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping enable aborts from any state
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = (WARMUP_BITS == 0) ? RUN : WARMUP;
        WARMUP:  if (warm_tick && warm_q == WARM_W'(WARMUP_BITS - 1)) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: a rise is the divider wrap that drives the mic clock from 0 to 1
  always_comb begin
    div_run   = (state_q != IDLE) && enable_i;
    div_wrap  = div_run && (count_q == CNT_W'(HALF - 1));
    rise      = div_wrap && !pdm_clk_q;
    warm_tick = rise && (state_q == WARMUP);
    capture   = rise && (state_q == RUN);
    word_done = capture && (idx_q == IDX_W'(WORD_LENGTH - 1));
  end

  always_comb begin
    count_d   = '0;
    pdm_clk_d = 1'b0;
    if (div_run) begin
      pdm_clk_d = div_wrap ? ~pdm_clk_q : pdm_clk_q;
      count_d   = div_wrap ? '0 : count_q + CNT_W'(1);
    end

    warm_d = '0;
    if (div_run && state_q == WARMUP) begin
      warm_d = warm_tick ? warm_q + WARM_W'(1) : warm_q;
    end

    idx_d = '0;
    if (div_run && state_q == RUN) begin
      if (word_done)    idx_d = '0;
      else if (capture) idx_d = idx_q + IDX_W'(1);
      else              idx_d = idx_q;
    end

    shift_d = capture ? {shift_q[WORD_LENGTH-2:0], pdm_data_i} : shift_q;

    // A completing word takes priority over an ack landing on the same edge
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (word_done) begin
      data_d  = shift_d;
      valid_d = 1'b1;
      if (valid_q && !word_if.ack_i) overrun_d = 1'b1;
    end else if (valid_q && word_if.ack_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      count_q   <= '0;
      pdm_clk_q <= 1'b0;
      warm_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pdm_clk_q <= pdm_clk_d;
      warm_q    <= warm_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign pdm_clk_o         = pdm_clk_q;
  assign pdm_lrsel_o       = 1'b0;
  assign word_if.Data_o    = data_q;
  assign word_if.valid_o   = valid_q;
  assign word_if.overrun_o = overrun_q;

endmodule

// File: tb/tb_pdm_deserializer.sv
// Bench for pdm_deserializer: two instances (no warmup / 4-bit warmup) share one stimulus
// and are compared against a bit-list model of the word stream and handshake.
module tb_pdm_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, pdm, ack;
  logic pclk0, plr0, pclk4, plr4;

  pdm_deserializer_if #(.WORD_LENGTH(16)) bus0 ();
  pdm_deserializer_if #(.WORD_LENGTH(16)) bus4 ();
  assign bus0.ack_i = ack;
  assign bus4.ack_i = ack;

  pdm_deserializer #(.WARMUP_BITS(0)) dut0 (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .pdm_data_i(pdm),
    .pdm_clk_o(pclk0), .pdm_lrsel_o(plr0), .word_if(bus0)
  );

  pdm_deserializer #(.WARMUP_BITS(4)) dut4 (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .pdm_data_i(pdm),
    .pdm_clk_o(pclk4), .pdm_lrsel_o(plr4), .word_if(bus4)
  );

  int checks = 0;
  int errors = 0;

  // Model: per instance, warmup length, rises seen, bits collected toward the current word
  int          warm [2] = '{0, 4};
  int          m_rises [2];
  int          m_nbits [2];
  logic [15:0] m_word [2];
  logic [15:0] m_data [2];
  logic        m_valid [2];
  logic        m_ovr [2];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "/d0.data"},  bus0.Data_o,    m_data[0]);
    check({tag, "/d0.valid"}, bus0.valid_o,   m_valid[0]);
    check({tag, "/d0.ovr"},   bus0.overrun_o, m_ovr[0]);
    check({tag, "/d4.data"},  bus4.Data_o,    m_data[1]);
    check({tag, "/d4.valid"}, bus4.valid_o,   m_valid[1]);
    check({tag, "/d4.ovr"},   bus4.overrun_o, m_ovr[1]);
  endtask

  task automatic model_restart();
    for (int i = 0; i < 2; i++) begin
      m_rises[i] = 0;
      m_nbits[i] = 0;
    end
  endtask

  task automatic model_reset();
    model_restart();
    for (int i = 0; i < 2; i++) begin
      m_word[i] = '0; m_data[i] = '0; m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
    end
  endtask

  // One mic-clock rise carrying bit b, with ack level a on that edge
  task automatic model_rise(input logic b, input logic a);
    for (int i = 0; i < 2; i++) begin
      bit done = 0;
      if (m_rises[i] < warm[i]) begin
        m_rises[i]++;
      end else begin
        m_word[i] = {m_word[i][14:0], b};
        m_nbits[i]++;
        if (m_nbits[i] == 16) begin
          m_nbits[i] = 0;
          done = 1;
          if (m_valid[i] && !a) m_ovr[i] = 1'b1;
          m_data[i]  = m_word[i];
          m_valid[i] = 1'b1;
        end
      end
      if (!done && a) m_valid[i] = 1'b0;
    end
  endtask

  // One mic period starting 25 clocks after a rise-phase reference; mode 1 = ack on the rise,
  // mode 2 = ack on a cycle well away from the rise
  task automatic mic_bit(input logic b, input int mode);
    pdm = b;
    repeat (25) @(negedge clk);
    cmp_model("pre");
    if (mode == 1) ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    model_rise(b, mode == 1);
    cmp_model("post");
    if (mode == 2) begin
      repeat (10) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      for (int i = 0; i < 2; i++) m_valid[i] = 1'b0;
      cmp_model("ack_mid");
      repeat (63) @(negedge clk);
    end else begin
      repeat (74) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int ack_pos, input int ack_mode);
    for (int j = 0; j < 16; j++) mic_bit(w[15-j], (j == ack_pos) ? ack_mode : 0);
  endtask

  task automatic do_enable();
    enable = 1'b1;
    model_restart();
    repeat (25) @(negedge clk);
  endtask

  task automatic do_disable();
    enable = 1'b0;
    @(negedge clk);
    check("abort/pclk0", pclk0, 0);
    check("abort/pclk4", pclk4, 0);
    model_restart();
    cmp_model("abort");
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    cmp_model("reset");
    check("reset/pclk0", pclk0, 0);
    check("reset/pclk4", pclk4, 0);
    check("reset/lrsel", plr0, 0);
    rst_n = 1'b1;
  endtask

  task automatic ack_idle();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    for (int i = 0; i < 2; i++) m_valid[i] = 1'b0;
    cmp_model("ack_idle");
  endtask

  initial begin
    logic [15:0] w;
    logic        exp_clk;
    rst_n = 1'b0; enable = 1'b0; pdm = 1'b0; ack = 1'b0;
    @(negedge clk);
    do_reset();

    // Mic clock: first rise 50 clocks after enable, then 50 high / 50 low
    enable = 1'b1;
    for (int k = 0; k <= 150; k++) begin
      @(negedge clk);
      if (k == 49 || k == 50 || k == 99 || k == 100 || k == 149 || k == 150) begin
        exp_clk = (k >= 50) && (((k - 50) / 50) % 2 == 0);
        check("clk/d0", pclk0, exp_clk);
        check("clk/d4", pclk4, exp_clk);
        check("clk/lrsel", plr0 | plr4, 0);
      end
    end
    do_disable();

    // Capture with no warmup
    do_enable();
    send_word(16'hA5C3, -1, 0);
    check("capture/data", bus0.Data_o, 16'hA5C3);
    check("capture/valid", bus0.valid_o, 1);
    do_disable();
    ack_idle();

    // Warmup: four leading 1s discarded by the 4-bit-warmup instance
    do_enable();
    for (int j = 0; j < 4; j++) mic_bit(1'b1, 0);
    send_word(16'h0F0F, -1, 0);
    check("warmup/data", bus4.Data_o, 16'h0F0F);
    do_disable();
    ack_idle();

    // Overrun across two unacked words, then ack
    do_enable();
    send_word(16'h1234, -1, 0);
    send_word(16'hBEEF, -1, 0);
    check("overrun/data", bus0.Data_o, 16'hBEEF);
    check("overrun/ovr", bus0.overrun_o, 1);
    do_disable();
    ack_idle();
    check("overrun/valid_after_ack", bus0.valid_o, 0);
    check("overrun/ovr_sticky", bus0.overrun_o, 1);

    // Collision: ack on the very edge that completes the next word
    do_reset();
    do_enable();
    w = 16'($urandom);
    send_word(w, -1, 0);
    send_word(16'h5555, 15, 1);
    check("collision/valid", bus0.valid_o, 1);
    check("collision/data", bus0.Data_o, 16'h5555);
    check("collision/ovr", bus0.overrun_o, 0);

    // Abort mid-word, then a clean word after re-enable
    for (int j = 0; j < 7; j++) mic_bit(1'b0, 0);
    do_disable();
    check("abort/data_held", bus0.Data_o, 16'h5555);
    check("abort/valid_held", bus0.valid_o, 1);
    ack_idle();
    do_enable();
    send_word(16'hFFFF, -1, 0);
    check("reenable/data", bus0.Data_o, 16'hFFFF);
    for (int j = 0; j < 7; j++) mic_bit(1'b0, 0);
    do_reset();

    // Random words with randomly placed acks
    do_enable();
    for (int n = 0; n < 10; n++) begin
      w = 16'($urandom);
      send_word(w, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      $display("word %0d sent %h: d0 data=%h valid=%0b ovr=%0b", n, w,
               bus0.Data_o, bus0.valid_o, bus0.overrun_o);
    end
    do_disable();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
